// File: rtl/mem_access_unit.sv
// MEM stage: runs loads/stores over a byte-wide req/ack port (little-endian, one byte per beat).
// Optional ME_ALIGN_CHECK_EN: misaligned halfword/word accesses issue no beats and raise misalign_o.
module mem_access_unit #(
  parameter int ADDR_W = 32,
  parameter int OP_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [OP_W-1:0]   aluop_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic              w_enable_i,
  input  logic [4:0]        w_addr_i,
  input  logic [31:0]       w_data_i,
  output logic              w_enable_o,
  output logic [4:0]        w_addr_o,
  output logic [31:0]       w_data_o,
  output logic              stall_req_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [7:0]        mem_wdata_o,
  input  logic [7:0]        mem_rdata_i,
  input  logic              mem_ack_i,
  output logic              misalign_o
);
  // AluOpBus encodings of the memory ops; anything else is a non-memory op.
  localparam logic [OP_W-1:0] EX_LB_OP  = OP_W'(8'hE0);
  localparam logic [OP_W-1:0] EX_LH_OP  = OP_W'(8'hE1);
  localparam logic [OP_W-1:0] EX_LW_OP  = OP_W'(8'hE3);
  localparam logic [OP_W-1:0] EX_LBU_OP = OP_W'(8'hE4);
  localparam logic [OP_W-1:0] EX_LHU_OP = OP_W'(8'hE5);
  localparam logic [OP_W-1:0] EX_SB_OP  = OP_W'(8'hE8);
  localparam logic [OP_W-1:0] EX_SH_OP  = OP_W'(8'hE9);
  localparam logic [OP_W-1:0] EX_SW_OP  = OP_W'(8'hEB);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [1:0]        k_q, k_d;
  logic [31:0]       buf_q, buf_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic              mis_q, mis_d;

  logic       is_load, is_store, is_sext, is_mem, misal;
  logic [1:0] last_k;

  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    is_sext  = 1'b0;
    last_k   = 2'd0;
    case (aluop_i)
      EX_LB_OP:  begin is_load = 1'b1; is_sext = 1'b1; end
      EX_LBU_OP: is_load = 1'b1;
      EX_LH_OP:  begin is_load = 1'b1; is_sext = 1'b1; last_k = 2'd1; end
      EX_LHU_OP: begin is_load = 1'b1; last_k = 2'd1; end
      EX_LW_OP:  begin is_load = 1'b1; last_k = 2'd3; end
      EX_SB_OP:  is_store = 1'b1;
      EX_SH_OP:  begin is_store = 1'b1; last_k = 2'd1; end
      EX_SW_OP:  begin is_store = 1'b1; last_k = 2'd3; end
      default: ;
    endcase
  end
  assign is_mem = is_load | is_store;

`ifdef ME_ALIGN_CHECK_EN
  assign misal = ((last_k == 2'd1) && mem_addr_i[0]) ||
                 ((last_k == 2'd3) && (mem_addr_i[1:0] != 2'b00));
  assign misalign_o = (state_q == S_DONE) && mis_q;
`else
  assign misal      = 1'b0;
  assign misalign_o = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    buf_d       = buf_q;
    req_d       = req_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    mis_d       = 1'b0;
    w_enable_o  = 1'b0;
    w_addr_o    = 5'd0;
    w_data_o    = 32'd0;
    stall_req_o = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (is_mem) begin
          stall_req_o = 1'b1;
          if (misal) begin
            state_d = S_DONE;
            mis_d   = 1'b1;
          end else begin
            state_d = S_ACCESS;
            req_d   = 1'b1;
            we_d    = is_store;
            k_d     = 2'd0;
            buf_d   = 32'd0;
            addr_d  = mem_addr_i;
            wdata_d = w_data_i[7:0];
          end
        end else begin
          w_enable_o = w_enable_i;
          w_addr_o   = w_addr_i;
          w_data_o   = w_data_i;
        end
      end
      S_ACCESS: begin
        stall_req_o = 1'b1;
        // Without ack every mem_* register simply holds: wait states are unbounded.
        if (mem_ack_i) begin
          buf_d[{k_q, 3'b000} +: 8] = mem_rdata_i;
          if (k_q == last_k) begin
            state_d = S_DONE;
            req_d   = 1'b0;
          end else begin
            k_d     = k_q + 2'd1;
            addr_d  = mem_addr_i + ADDR_W'(k_d);
            wdata_d = w_data_i[{k_d, 3'b000} +: 8];
          end
        end
      end
      S_DONE: begin
        state_d  = S_IDLE;
        w_addr_o = w_addr_i;
        if (is_load && !mis_q) begin
          w_enable_o = w_enable_i;
          case (last_k)
            2'd0:    w_data_o = is_sext ? {{24{buf_q[7]}}, buf_q[7:0]}   : {24'd0, buf_q[7:0]};
            2'd1:    w_data_o = is_sext ? {{16{buf_q[15]}}, buf_q[15:0]} : {16'd0, buf_q[15:0]};
            default: w_data_o = buf_q;
          endcase
        end else begin
          w_enable_o = 1'b0;
          w_data_o   = w_data_i;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Outputs read as zero while reset is held, even the combinational pass-through.
    if (rst) begin
      w_enable_o  = 1'b0;
      w_addr_o    = 5'd0;
      w_data_o    = 32'd0;
      stall_req_o = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      k_q     <= 2'd0;
      buf_q   <= 32'd0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 8'd0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      buf_q   <= buf_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      mis_q   <= mis_d;
    end
  end

  assign mem_req_o   = req_q;
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized bench for mem_access_unit against a byte-array memory model with random wait states.
module tb_mem_access_unit;
  localparam logic [7:0] LB = 8'hE0, LH = 8'hE1, LW = 8'hE3, LBU = 8'hE4, LHU = 8'hE5;
  localparam logic [7:0] SB = 8'hE8, SH = 8'hE9, SW = 8'hEB, ADD = 8'h20, NOP = 8'h00;

  logic        clk = 1'b0, rst = 1'b1;
  logic [7:0]  aluop_i = NOP;
  logic [31:0] mem_addr_i = '0, w_data_i = '0;
  logic        w_enable_i = 1'b0;
  logic [4:0]  w_addr_i = '0;
  logic        w_enable_o, stall_req_o, mem_req_o, mem_we_o, misalign_o;
  logic [4:0]  w_addr_o;
  logic [31:0] w_data_o, mem_addr_o;
  logic [7:0]  mem_wdata_o, mem_rdata_i = '0;
  logic        mem_ack_i = 1'b0;

  int vectors = 0, miscompares = 0;
  logic [7:0] mem_m [logic [31:0]];

  mem_access_unit dut (
    .clk(clk), .rst(rst), .aluop_i(aluop_i), .mem_addr_i(mem_addr_i),
    .w_enable_i(w_enable_i), .w_addr_i(w_addr_i), .w_data_i(w_data_i),
    .w_enable_o(w_enable_o), .w_addr_o(w_addr_o), .w_data_o(w_data_o),
    .stall_req_o(stall_req_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
    .mem_ack_i(mem_ack_i), .misalign_o(misalign_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] mem_rd(input logic [31:0] a);
    if (!mem_m.exists(a)) mem_m[a] = 8'($urandom);
    return mem_m[a];
  endfunction

  function automatic int nbytes(input logic [7:0] op);
    case (op)
      LB, LBU, SB: return 1;
      LH, LHU, SH: return 2;
      LW, SW:      return 4;
      default:     return 0;
    endcase
  endfunction

  // One full operation, starting at a negedge with the DUT idle.
  task automatic run_op(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] wd,
                        input logic wen, input logic [4:0] wa, input int waits);
    int n, beat, wc, stalls;
    bit st, sx, mis, done, req_s;
    logic [31:0] exp, a_s;
    @(negedge clk);
    n  = nbytes(op);
    st = (op == SB) || (op == SH) || (op == SW);
    sx = (op == LB) || (op == LH);
    mis = 1'b0;
`ifdef ME_ALIGN_CHECK_EN
    mis = ((n == 2) && addr[0]) || ((n == 4) && (addr[1:0] != 2'b00));
`endif
    exp = 32'd0;
    for (int i = 0; i < n; i++) exp = exp + (32'(mem_rd(addr + 32'(i))) << (8 * i));
    if (sx && exp[8*n-1]) exp = exp | (32'hFFFF_FFFF << (8 * n));
    aluop_i = op; mem_addr_i = addr; w_data_i = wd; w_enable_i = wen; w_addr_i = wa;
    mem_ack_i = 1'b0;
    #1;
    if (n == 0) begin
      chk("pass_stall", stall_req_o, 0);
      chk("pass_en", w_enable_o, wen);
      chk("pass_addr", w_addr_o, wa);
      chk("pass_data", w_data_o, wd);
      chk("pass_req", mem_req_o, 0);
      return;
    end
    beat = 0; wc = 0; stalls = 0; done = 0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      if (cyc == 0) chk("idle_stall", stall_req_o, 1);
      if (!stall_req_o && cyc > 0) begin done = 1; break; end
      if (stall_req_o) stalls++;
      req_s = mem_req_o; a_s = mem_addr_o;
      if (req_s && beat < n) begin
        if (wc == 0) begin
          chk("beat_addr", mem_addr_o, addr + 32'(beat));
          chk("beat_we", mem_we_o, st);
          if (st) chk("beat_wdata", mem_wdata_o, (wd >> (8 * beat)) & 32'hFF);
        end
        mem_ack_i   = (wc == waits);
        mem_rdata_i = mem_ack_i ? mem_rd(a_s) : 8'($urandom);
      end else begin
        mem_ack_i   = !req_s && ($urandom_range(0, 1) == 1);
        mem_rdata_i = 8'($urandom);
      end
      @(posedge clk);
      if (req_s && beat < n) begin
        if (mem_ack_i) begin
          if (st) mem_m[a_s] = 8'(wd >> (8 * beat));
          beat++; wc = 0;
        end else wc++;
      end
      @(negedge clk);
    end
    mem_ack_i = 1'b0;
    chk("completed", 32'(done), 1);
    if (!done) return;
    chk("stall_cycles", stalls, mis ? 1 : n + 1 + n * waits);
    chk("beat_count", beat, mis ? 0 : n);
    chk("done_req", mem_req_o, 0);
    chk("misalign", misalign_o, mis);
    chk("done_en", w_enable_o, (!st && !mis) ? wen : 1'b0);
    if (!st && !mis) begin
      chk("load_data", w_data_o, exp);
      chk("load_addr", w_addr_o, wa);
    end
  endtask

  initial begin
    logic [7:0] ops [10];
    bit found;
    ops = '{LB, LH, LW, LBU, LHU, SB, SH, SW, ADD, NOP};
    aluop_i = ADD; w_enable_i = 1'b1; w_addr_i = 5'd3; w_data_i = 32'h5;
    #12;
    chk("rst_stall", stall_req_o, 0);
    chk("rst_en", w_enable_o, 0);
    chk("rst_data", w_data_o, 0);
    chk("rst_req", mem_req_o, 0);
    chk("rst_maddr", mem_addr_o, 0);
    @(negedge clk); rst = 1'b0;

    run_op(ADD, 32'h0, 32'h5, 1'b1, 5'd3, 0);
    run_op(SW, 32'h100, 32'h1122_3344, 1'b0, 5'd0, 0);
    run_op(LW, 32'h100, 32'h0, 1'b1, 5'd4, 1);
    mem_m[32'h7] = 8'h80;
    run_op(LB, 32'h7, 32'h0, 1'b1, 5'd5, 0);
    run_op(LBU, 32'h7, 32'h0, 1'b1, 5'd6, 0);
    mem_m[32'h10] = 8'h34; mem_m[32'h11] = 8'hF2;
    run_op(LH, 32'h10, 32'h0, 1'b1, 5'd7, 3);
    run_op(LW, 32'hFFFF_FFFE, 32'h0, 1'b1, 5'd8, 0);
    run_op(LW, 32'h102, 32'h0, 1'b1, 5'd9, 0);
    run_op(ADD, 32'h0, 32'hDEAD_BEEF, 1'b1, 5'd0, 0);

    // Reset in the middle of a store, while beat 2 is on the bus.
    @(negedge clk);
    aluop_i = SW; mem_addr_i = 32'h200; w_data_i = 32'hAABB_CCDD; w_enable_i = 1'b0;
    found = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (mem_req_o && mem_addr_o == 32'h202) begin found = 1; break; end
      mem_ack_i = mem_req_o;
    end
    mem_ack_i = 1'b0;
    chk("rst_mid_reached", 32'(found), 1);
    mem_m[32'h200] = 8'hDD; mem_m[32'h201] = 8'hCC;
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_req", mem_req_o, 0);
    chk("rst_mid_stall", stall_req_o, 0);
    chk("rst_mid_we", mem_we_o, 0);
    chk("rst_mid_maddr", mem_addr_o, 0);
    chk("rst_mid_wdata", mem_wdata_o, 0);
    chk("rst_mid_wout", {w_enable_o, w_addr_o, w_data_o[25:0]}, 0);
    @(negedge clk); aluop_i = NOP; rst = 1'b0;
    run_op(LW, 32'h200, 32'h0, 1'b1, 5'd10, 0);

    for (int it = 0; it < 250; it++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFC + 32'($urandom_range(0, 3))) : $urandom;
      run_op(ops[$urandom_range(0, 9)], a, $urandom, 1'($urandom), 5'($urandom),
             $urandom_range(0, 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
